// File: rtl/fetch_stage_pq.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue in front of decode.
// Issues one request per cycle to a 1-cycle-latency IMem; redirect flushes and kills the in-flight response.
`timescale 1ns/1ps
module fetch_stage_pq #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     STALL_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_inst,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_npc,
    output logic [STALL_W-1:0] stall_count
);

    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam int unsigned     CNT_W    = PTR_W + 1;
    localparam logic [XLEN-1:0] LP_STEP  = XLEN'(PC_STEP);
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + LP_STEP;
    endfunction

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

    logic [XLEN-1:0]    r_fetch_pc;
    logic               r_vld_p1;
    logic [XLEN-1:0]    r_pc_p1;

    logic [XLEN-1:0]    r_q_inst [DEPTH];
    logic [XLEN-1:0]    r_q_pc   [DEPTH];
    logic [XLEN-1:0]    r_q_npc  [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [STALL_W-1:0] r_stall_count;

    logic               w_valid;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_occ;

    // Queue slots plus the outstanding response must fit, so a push never overflows.
    assign w_occ    = r_count + {{(CNT_W-1){1'b0}}, r_vld_p1};
    assign w_valid  = (r_count != '0);
    assign w_req    = !reset && !redirect_valid && (w_occ < LP_DEPTH);
    assign w_push   = r_vld_p1 && !redirect_valid && !reset;
    assign w_pop    = w_valid && id_ready;

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign stall_count = r_stall_count;

    // Head is presented straight from storage, zeroed when empty.
    assign if_valid = w_valid;
    assign if_inst  = w_valid ? r_q_inst[r_rd_ptr] : '0;
    assign if_pc    = w_valid ? r_q_pc[r_rd_ptr]   : '0;
    assign if_npc   = w_valid ? r_q_npc[r_rd_ptr]  : '0;

    // Stage p0 -> p1: fetch PC and request tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= w_req;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_req) begin
                r_fetch_pc <= pc_next(r_fetch_pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req) begin
            r_pc_p1 <= r_fetch_pc;
        end
    end

    // Stage p1 -> queue: response capture
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= r_pc_p1;
            r_q_npc[r_wr_ptr]  <= pc_next(r_pc_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_valid && !id_ready) begin
            r_stall_count <= sat_inc(r_stall_count);
        end
    end

endmodule

// File: doc/fetch_stage_pq.md
Name: fetch_stage_pq

Overview:
- Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register IF/ID latch.
- Holds a fetch PC and issues one request per cycle to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers up to DEPTH fetched instructions with their PC and next-PC, and presents them to decode through a valid/ready handshake.
- Handles branch redirect with full flush and kill of the in-flight response, and counts backpressure (hazard) cycles in a saturating counter.

Parameters:
XLEN, 32, width of PC, NPC and instruction words
DEPTH, 4, prefetch queue entries; power of two, minimum 2
PC_STEP, 1, PC increment per instruction (1 = word-addressed IMem, 4 = byte-addressed)
RESET_PC, 0, fetch PC loaded on reset
STALL_W, 2, width of the stall counter

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
redirect_valid  input  1  branch taken (EX/MEM cond); flush and refetch
redirect_pc  input  XLEN  branch target (EX/MEM ALU output)
id_ready  input  1  decode accepts the head entry; low = hazard stall
imem_req  output  1  fetch request this cycle
imem_addr  output  XLEN  fetch address; equals fetch_pc
imem_rdata  input  XLEN  instruction for the request issued in the previous cycle
if_valid  output  1  head entry valid
if_inst  output  XLEN  head instruction
if_pc  output  XLEN  head instruction PC
if_npc  output  XLEN  head PC + PC_STEP
stall_count  output  STALL_W  saturating count of stalled cycles

Behaviour:
- Reset (any cycle, including mid-stream):
  - fetch_pc = RESET_PC; queue empty; in-flight flag cleared.
  - if_valid = 0; if_inst, if_pc and if_npc = 0; stall_count = 0; imem_req = 0 during the reset cycle.
- Request issue:
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc, combinational from the register.
  - On each issued request: fetch_pc += PC_STEP, modulo 2^XLEN (wraps silently); inflight <= 1. Otherwise inflight <= 0.
  - Each request records its PC in a one-entry in-flight register.
- Response:
  - In the cycle after a request, imem_rdata is pushed at the clock edge as {inst, pc, pc+PC_STEP}.
  - The push is suppressed if redirect_valid or reset is high in that cycle.
- Pop:
  - Occurs when if_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - The outputs show the queue head. They are driven from storage with no combinational path from imem_rdata or id_ready.
- Flow control:
  - The issue condition guarantees a push never finds the queue full. An overflow is a design bug; the bench checks it with an assertion.
  - A pop from an empty queue cannot occur, because if_valid is low when the queue is empty.
- Redirect (priority over stall and normal fetch):
  - In cycle R with redirect_valid=1: fetch_pc <= redirect_pc; queue count <= 0; any in-flight response is discarded; no request is issued.
  - Cycle R+1: imem_req=1, imem_addr=redirect_pc.
  - Cycle R+2: data returns and is pushed.
  - Cycle R+3: if_valid=1, if_pc=redirect_pc.
  - A redirect while id_ready=0 still flushes; stall_count still increments that cycle if if_valid was 1.
- Stall counter:
  - Increments by 1 in every cycle with if_valid && !id_ready.
  - Saturates at 2^STALL_W - 1; never wraps.
  - Cleared only by reset.
- Steady state with id_ready=1 and no redirect: one instruction delivered per cycle, with PCs increasing by PC_STEP.
- Startup latency from reset deassertion: first if_valid in the 3rd cycle.

Test Plan:
1. Reset, then stream with id_ready=1, IMem[i]=0x1000+i, PC_STEP=1 -> if_valid rises in cycle 3. if_pc/if_inst = 0/0x1000, 1/0x1001, ... on consecutive cycles; if_npc = if_pc+1.
2. id_ready=0 from cycle 3 for 10 cycles, DEPTH=4 -> queue holds PCs 0..3 and imem_req drops. Head stays pc=0. stall_count = 3 (saturated, STALL_W=2). After release, PCs 0,1,2,3,4... are delivered with no gap or duplicate.
3. Redirect to 0x40 while an entry is in flight -> that response is dropped. No stale PCs appear after R. Cycle R+1 imem_addr=0x40; cycle R+3 if_pc=0x40, if_npc=0x41.
4. Redirect to 0x80 coincident with id_ready=0 and a full queue -> queue empties, stall_count increments once, and the first valid output is pc=0x80 at R+3.
5. PC_STEP=4, fetch_pc at 0xFFFFFFF8 -> delivered PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap). if_npc of the last entry is 0x4.
6. Assert reset for one cycle mid-stream with a full queue and an in-flight request -> next cycle if_valid=0 and stall_count=0; the in-flight data is not pushed; fetch restarts at RESET_PC.
